// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB completer register file
package apb_pkg;
  typedef enum logic {ST_IDLE, ST_ACCESS} apb_slv_state_t;

  localparam logic APB_ERR_OK  = 1'b0;
  localparam logic APB_ERR_SLV = 1'b1;
endpackage

// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between bridge (master) and completer (slave)
interface apb_slave_regfile_if #(parameter int WIDTH = 16) ();
  logic             pselect;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic             pready;
  logic [WIDTH-1:0] prdata;
  logic             pslverr;

  modport master (
    output pselect, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselect, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile_mem.sv
// rtl/apb_regfile_mem.sv - DEPTH x WIDTH storage; word 0 is not stored and reads as 0
module apb_regfile_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH-1:1];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr == '0) ? '0 : r_mem[i_raddr];
endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with programmable wait states and a register file.
// Word 0 is a read-only ID; out-of-range or ID writes answer with pslverr.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 8,
  parameter int               WAIT_STATES = 1,
  parameter logic [WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
  input logic              pclk,
  input logic              preset,
  apb_slave_regfile_if.slave bus
);
  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int AW = $clog2(DEPTH);

  apb_slv_state_t   r_state, w_next_state;
  logic [CW-1:0]    r_cnt, w_next_cnt;
  logic [WIDTH-1:0] r_addr, r_wdata;
  logic             r_write;
  logic             w_ready, w_in_range, w_err, w_we;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] w_mem_rdata;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (r_state == ST_IDLE && bus.pselect && !bus.penable) begin
        r_addr  <= bus.paddr;
        r_wdata <= bus.pwdata;
        r_write <= bus.pwrite;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.pselect && !bus.penable) begin
          w_next_state = ST_ACCESS;
          w_next_cnt   = CW'(WAIT_STATES);
        end
      end
      ST_ACCESS: begin
        // Dropping pselect mid-transfer aborts; counter returns to 0 so IDLE holds it there.
        if (!bus.pselect) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == '0) begin
          w_ready      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (bus.penable) begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_idx      = r_addr[AW-1:0];
  assign w_in_range = ~|(r_addr >> AW);
  assign w_err      = !w_in_range || (r_write && (w_idx == '0));
  assign w_we       = w_ready && r_write && !w_err;

  apb_regfile_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk   (pclk),
    .i_clr   (preset),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  assign bus.pready  = w_ready;
  assign bus.pslverr = (w_ready && w_err) ? APB_ERR_SLV : APB_ERR_OK;
  assign bus.prdata  = (!w_ready || r_write || w_err) ? '0 :
                       (w_idx == '0) ? ID_VALUE : w_mem_rdata;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - bench for apb_slave_regfile at WAIT_STATES 0, 1 and 3.
module tb_apb_slave_regfile;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        b_sel = 1'b0, b_en = 1'b0, b_wr = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  int          cur = 0;
  int          vectors = 0;
  int          errors = 0;
  int          ws_of [3] = '{0, 1, 3};
  logic [15:0] mdl [3][8];
  logic        o_ready, o_err;
  logic [15:0] o_rdata;

  always #5 pclk = ~pclk;

  apb_slave_regfile_if #(.WIDTH(16)) bus0 ();
  apb_slave_regfile_if #(.WIDTH(16)) bus1 ();
  apb_slave_regfile_if #(.WIDTH(16)) bus3 ();

  assign bus0.pselect = b_sel && (cur == 0);
  assign bus1.pselect = b_sel && (cur == 1);
  assign bus3.pselect = b_sel && (cur == 2);
  assign bus0.penable = b_en;   assign bus1.penable = b_en;   assign bus3.penable = b_en;
  assign bus0.pwrite  = b_wr;   assign bus1.pwrite  = b_wr;   assign bus3.pwrite  = b_wr;
  assign bus0.paddr   = b_addr; assign bus1.paddr   = b_addr; assign bus3.paddr   = b_addr;
  assign bus0.pwdata  = b_wdata; assign bus1.pwdata = b_wdata; assign bus3.pwdata = b_wdata;

  apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(0), .ID_VALUE(16'hA5B0))
    u_ws0 (.pclk(pclk), .preset(preset), .bus(bus0));
  apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(1), .ID_VALUE(16'hA5B0))
    u_ws1 (.pclk(pclk), .preset(preset), .bus(bus1));
  apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(3), .ID_VALUE(16'hA5B0))
    u_ws3 (.pclk(pclk), .preset(preset), .bus(bus3));

  always_comb begin
    case (cur)
      0:       begin o_ready = bus0.pready; o_err = bus0.pslverr; o_rdata = bus0.prdata; end
      1:       begin o_ready = bus1.pready; o_err = bus1.pslverr; o_rdata = bus1.prdata; end
      default: begin o_ready = bus3.pready; o_err = bus3.pslverr; o_rdata = bus3.prdata; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) mdl[i][k] = '0;
  endtask

  // One complete transfer; checks the exact cycle pready appears and the response fields.
  task automatic xfer(input int inst, input bit wr, input logic [15:0] addr, input logic [15:0] data);
    bit          exp_err;
    logic [15:0] exp_rd;
    int          ws;
    ws = ws_of[inst];
    exp_err = (addr >= 16'd8) || (wr && addr == 16'd0);
    if (exp_err || wr)       exp_rd = '0;
    else if (addr == 16'd0)  exp_rd = 16'hA5B0;
    else                     exp_rd = mdl[inst][addr[2:0]];
    @(posedge pclk); #1;
    cur = inst; b_sel = 1'b1; b_en = 1'b0; b_wr = wr; b_addr = addr; b_wdata = data;
    @(negedge pclk);
    check("setup_ready", {31'd0, o_ready}, 32'd0);
    @(posedge pclk); #1;
    b_en = 1'b1; b_wdata = 16'($urandom);
    for (int n = 1; n <= ws + 1; n++) begin
      @(negedge pclk);
      if (n < ws + 1) begin
        check("wait_ready", {31'd0, o_ready}, 32'd0);
        check("wait_rdata", {16'd0, o_rdata}, 32'd0);
        @(posedge pclk); #1;
      end else begin
        check("done_ready", {31'd0, o_ready}, 32'd1);
        check("done_err", {31'd0, o_err}, {31'd0, exp_err});
        check("done_rdata", {16'd0, o_rdata}, {16'd0, exp_rd});
      end
    end
    if (wr && !exp_err) mdl[inst][addr[2:0]] = data;
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    b_sel = 1'b0; b_en = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_rdata", {16'd0, o_rdata}, 32'd0);

    // Basic write/read, ID word, out-of-range decode on WAIT_STATES=1
    xfer(1, 1'b1, 16'd3, 16'h1234);  go_idle();
    xfer(1, 1'b0, 16'd3, 16'h0000);
    xfer(1, 1'b0, 16'd0, 16'h0000);
    xfer(1, 1'b1, 16'd0, 16'hFFFF);
    xfer(1, 1'b0, 16'd0, 16'h0000);
    xfer(1, 1'b0, 16'd8, 16'h0000);
    xfer(1, 1'b1, 16'h0103, 16'hDEAD);
    xfer(1, 1'b0, 16'd3, 16'h0000);
    xfer(1, 1'b1, 16'd1, 16'h00AA);
    xfer(1, 1'b1, 16'd2, 16'h00BB);
    xfer(1, 1'b0, 16'd1, 16'h0000);
    xfer(1, 1'b0, 16'd2, 16'h0000);
    go_idle();

    // Abort by dropping pselect mid-wait on WAIT_STATES=3
    @(posedge pclk); #1;
    cur = 2; b_sel = 1'b1; b_en = 1'b0; b_wr = 1'b1; b_addr = 16'd4; b_wdata = 16'h5555;
    @(posedge pclk); #1 b_en = 1'b1;
    @(posedge pclk); #1 b_sel = 1'b0;
    @(negedge pclk);
    check("abort_ready", {31'd0, o_ready}, 32'd0);
    b_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("abort_idle_ready", {31'd0, o_ready}, 32'd0);
    end
    xfer(2, 1'b0, 16'd4, 16'h0000);
    go_idle();

    // Reset during ACCESS on WAIT_STATES=1
    @(posedge pclk); #1;
    cur = 1; b_sel = 1'b1; b_en = 1'b0; b_wr = 1'b1; b_addr = 16'd5; b_wdata = 16'h7777;
    @(posedge pclk); #1 b_en = 1'b1; preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; b_sel = 1'b0; b_en = 1'b0;
    model_clear();
    @(negedge pclk);
    check("rst_mid_ready", {31'd0, o_ready}, 32'd0);
    xfer(1, 1'b0, 16'd5, 16'h0000);
    xfer(1, 1'b0, 16'd3, 16'h0000);
    go_idle();

    // WAIT_STATES=0 regression, back-to-back
    xfer(0, 1'b1, 16'd6, 16'hBEEF);
    xfer(0, 1'b0, 16'd6, 16'h0000);
    xfer(0, 1'b1, 16'd7, 16'h0F0F);
    xfer(0, 1'b0, 16'd7, 16'h0000);
    go_idle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      int          inst, r;
      logic [15:0] a;
      inst = $urandom_range(0, 2);
      r = $urandom_range(0, 11);
      a = (r < 8) ? 16'(r) : 16'($urandom);
      xfer(inst, 1'($urandom), a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    for (int inst = 0; inst < 3; inst++)
      for (int k = 0; k < 8; k++) xfer(inst, 1'b0, 16'(k), 16'h0000);
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
